cnt_bank_arb: RTL and testbench
===============================

# cnt_bank_arb

Round-robin controller that shares one 8-bit adder among four counter registers `a`, `b`, `c`, `d`, each with its own increment requester. It replaces per-register adders in the generated counter top: requesters raise a level request, the arbiter grants one per cycle, and a two-stage pipeline (select, then add/write-back) updates the granted register. Operand forwarding keeps back-to-back grants to the same counter correct.

## Interface
Parameters:
- `WIDTH`, 8, counter and step width
- `INIT`, 0, reset value of every counter

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `req`  in  4  per-counter increment request, bit 0 = `a` … bit 3 = `d`; level, held until granted
- `step`  in  WIDTH  increment amount, sampled in the grant cycle
- `hold`  in  1  suppresses all grants while high; in-flight op still completes
- `gnt`  out  4  one-hot grant, combinational, at most one bit high
- `busy`  out  1  pipeline stage 2 holds a valid op
- `a`, `b`, `c`, `d`  out  WIDTH  counter registers

## Operation
- Arbiter: round-robin over `req & ~{4{hold}}`, starting search at `ptr`; `ptr` (2 bits) moves to granted index + 1 (mod 4) on every grant, unchanged otherwise.
- A request is consumed in the cycle its `gnt` bit is high; requester drops or re-asserts `req` next cycle (re-assertion = new increment).
- Stage 1 (grant cycle): latch `idx`, `step`, `vld`=1 into the pipeline register; no grant → `vld`=0.
- Stage 2: operand = current register[`idx`], or the stage-2 result of the previous op when it targeted the same `idx` (forwarding); sum = operand + `step`, truncated to WIDTH (wrap, 0xFF + 1 = 0x00) unless saturation is compiled in; written at the end of stage 2.
- `busy` = stage-2 `vld`.
- Reset (any time, including mid-op): counters = `INIT`, `ptr`=0, all `vld`=0, in-flight op discarded; `gnt` = 0 while `rst` is high.

## Timing
- Grant at cycle t → counter value visible at output at t+2; throughput one increment per cycle.
- Same counter granted at t and t+1 with `step`=1 → +2 visible at t+3, no lost update.
- Two ops to different counters in consecutive cycles: no interaction.
- `hold` rising at t: no `gnt` from t; an op granted at t−1 still writes at end of t.
- All four requests constant high, no hold: grants a, b, c, d, a, … one per cycle.
- Reset values: `gnt`=0, `busy`=0, `a`..`d`=`INIT`.

## Configuration
- `CNT_BANK_ARB_SAT_EN` defined: sum clamps to 2^WIDTH−1 (0xFE + 5 = 0xFF); forwarding uses the clamped value.
- Undefined: modulo-2^WIDTH wrap.

## Structure
- Shared package `cnt_bank_pkg`: `NUM_CNT`=4, `idx_t` (2-bit), `op_t` struct {vld, idx, step}.
- Sub-module `rr_arb4`: request vector + pointer in, one-hot grant + next pointer out; pure combinational, reused elsewhere.
- Counters, pipeline register and forwarding mux live in `cnt_bank_arb`.

## Test plan
- Reset mid-op: grant `b` with `step`=3 at t, assert `rst` at t+1 → `b`=0, `busy`=0, no write after release.
- Single requester: `req`=0001, `step`=1 for 8 grant cycles → `a`=8 two cycles after last grant, others 0.
- Fairness: `req`=1111 held 8 cycles, `step`=1 → `gnt` sequence a,b,c,d,a,b,c,d; final a=b=c=d=2.
- Forwarding: `req`=0100 for 3 consecutive cycles, `step`=2 → `c`=6 at third grant + 2, no lost update.
- Hold: `req`=1010, `hold` high 5 cycles → `gnt`=0 throughout, counters unchanged; after release, `b` then `d` granted.
- Overflow: preload `d` to 0xFE (254 grants, `step`=1), then `step`=5 → `d`=0x03 without macro, 0xFF with `CNT_BANK_ARB_SAT_EN`.

Source files
------------

// File: rtl/cnt_bank_pkg.sv
// Shared types for the counter bank: counter count, counter index and the
// pipeline op descriptor carried from the grant cycle into the add stage.
package cnt_bank_pkg;

  localparam int NUM_CNT = 4;
  // Step field width of op_t; the bank supports counter widths up to this.
  localparam int STEP_W  = 8;

  typedef logic [1:0] idx_t;

  typedef struct packed {
    logic              vld;
    idx_t              idx;
    logic [STEP_W-1:0] step;
  } op_t;

endpackage

// File: rtl/cnt_bank_arb_rr_arb4.sv
// rr_arb4: four-way round-robin arbiter, purely combinational.
// Searches the request vector starting at ptr, returns a one-hot grant and
// the pointer value that follows the granted index (ptr unchanged if idle).
module rr_arb4
  import cnt_bank_pkg::*;
(
  input  logic [NUM_CNT-1:0] req,
  input  idx_t               ptr,
  output logic [NUM_CNT-1:0] gnt,
  output idx_t               ptr_nxt
);

  idx_t cand;
  logic found;

  // First requester at or after ptr (wrapping) wins.
  always_comb begin
    gnt     = '0;
    ptr_nxt = ptr;
    cand    = ptr;
    found   = 1'b0;
    for (int k = 0; k < NUM_CNT; k++) begin
      cand = ptr + idx_t'(k);
      if (!found && req[cand]) begin
        gnt[cand] = 1'b1;
        ptr_nxt   = cand + idx_t'(1);
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cnt_bank_arb.sv
// cnt_bank_arb: four counters (a..d) sharing one adder through a round-robin
// arbiter and a two-stage pipeline (grant/select, then add/write-back).
// Build option: define CNT_BANK_ARB_SAT_EN to clamp sums at 2^WIDTH-1
// instead of wrapping.
module cnt_bank_arb
  import cnt_bank_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int INIT  = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_CNT-1:0] req,
  input  logic [WIDTH-1:0]   step,
  input  logic               hold,
  output logic [NUM_CNT-1:0] gnt,
  output logic               busy,
  output logic [WIDTH-1:0]   a,
  output logic [WIDTH-1:0]   b,
  output logic [WIDTH-1:0]   c,
  output logic [WIDTH-1:0]   d
);

  function automatic logic [WIDTH-1:0] add_step(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] s);
`ifdef CNT_BANK_ARB_SAT_EN
    logic [WIDTH:0] full;
    full = {1'b0, x} + {1'b0, s};
    return full[WIDTH] ? {WIDTH{1'b1}} : full[WIDTH-1:0];
`else
    return x + s;
`endif
  endfunction

  function automatic idx_t oh2idx(input logic [NUM_CNT-1:0] oh);
    idx_t r;
    r = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (oh[i]) r = idx_t'(i);
    end
    return r;
  endfunction

  logic [NUM_CNT-1:0] req_m;
  logic [NUM_CNT-1:0] gnt_w;
  idx_t               ptr;
  idx_t               ptr_nxt;
  op_t                op_nxt;
  op_t                op_p1;
  logic               vld_p2;
  idx_t               idx_p2;
  logic [WIDTH-1:0]   sum_p2;
  logic [WIDTH-1:0]   operand;
  logic [WIDTH-1:0]   sum_w;
  logic [WIDTH-1:0]   cnt [NUM_CNT];

  // Hold and reset both mask every request so no grant can escape.
  assign req_m = req & ~{NUM_CNT{hold | rst}};

  rr_arb4 u_arb (
    .req     (req_m),
    .ptr     (ptr),
    .gnt     (gnt_w),
    .ptr_nxt (ptr_nxt)
  );

  assign gnt = gnt_w;

  // Stage 0 -> 1: the grant cycle builds the op descriptor.
  always_comb begin
    op_nxt      = '0;
    op_nxt.vld  = |gnt_w;
    op_nxt.idx  = oh2idx(gnt_w);
    op_nxt.step = STEP_W'(step);
  end

  // Round-robin pointer; the arbiter already returns ptr when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr <= '0;
    else     ptr <= ptr_nxt;
  end

  // Pipeline register between select and add; only vld is cleared on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) op_p1.vld <= 1'b0;
    else     op_p1     <= op_nxt;
  end

  // Stage 2: add, forwarding the previous result when it hit the same counter.
  assign operand = (vld_p2 && (idx_p2 == op_p1.idx)) ? sum_p2 : cnt[op_p1.idx];
  assign sum_w   = add_step(operand, WIDTH'(op_p1.step));
  assign busy    = op_p1.vld;

  // Valid tag of the last written result, used by the forwarding compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_p2 <= 1'b0;
    else     vld_p2 <= op_p1.vld;
  end

  // Data of the last written result; meaningful only while vld_p2 is set.
  always_ff @(posedge clk) begin
    if (op_p1.vld) begin
      idx_p2 <= op_p1.idx;
      sum_p2 <= sum_w;
    end
  end

  // Counter write-back at the end of stage 2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CNT; i++) cnt[i] <= WIDTH'(INIT);
    end else if (op_p1.vld) begin
      cnt[op_p1.idx] <= sum_w;
    end
  end

  assign a = cnt[0];
  assign b = cnt[1];
  assign c = cnt[2];
  assign d = cnt[3];

endmodule

// File: tb/tb_cnt_bank_arb.sv
// Bench for cnt_bank_arb: directed scenarios followed by random traffic, all
// checked every cycle against a grant-order reference model.
module tb_cnt_bank_arb;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [7:0] step;
  logic       hold;
  logic [3:0] gnt;
  logic       busy;
  logic [7:0] a, b, c, d;

  int checks;
  int errors;

  // Reference model: s1 = counters after all grants up to the previous
  // cycle, s2 = counters after grants up to two cycles ago (what the outputs
  // should show now).
  int m_ptr;
  int s1 [4];
  int s2 [4];
  bit m_busy;

  cnt_bank_arb #(.WIDTH(8), .INIT(0)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .step (step),
    .hold (hold),
    .gnt  (gnt),
    .busy (busy),
    .a    (a),
    .b    (b),
    .c    (c),
    .d    (d)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic int add_model(input int x, input int s);
`ifdef CNT_BANK_ARB_SAT_EN
    return (x + s > 255) ? 255 : x + s;
`else
    return (x + s) % 256;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check all outputs mid-cycle, advance model.
  task automatic cyc(input logic [3:0] r, input logic [7:0] s, input logic h, input logic rs);
    int g;
    logic [3:0] eg;
    req  = r;
    step = s;
    hold = h;
    rst  = rs;
    @(negedge clk);
    if (rs) begin
      for (int i = 0; i < 4; i++) begin
        s1[i] = 0;
        s2[i] = 0;
      end
      m_busy = 1'b0;
      m_ptr  = 0;
    end
    g = -1;
    if (!rs && !h) begin
      for (int k = 0; k < 4; k++) begin
        if (g < 0 && r[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
      end
    end
    eg = (g >= 0) ? (4'b0001 << g) : 4'b0000;
    chk("gnt", 32'(gnt), 32'(eg));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("a", 32'(a), 32'(s2[0]));
    chk("b", 32'(b), 32'(s2[1]));
    chk("c", 32'(c), 32'(s2[2]));
    chk("d", 32'(d), 32'(s2[3]));
    for (int i = 0; i < 4; i++) s2[i] = s1[i];
    m_busy = (g >= 0);
    if (g >= 0) begin
      s1[g] = add_model(s1[g], int'(s));
      m_ptr = (g + 1) % 4;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(4'b0000, 8'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    cyc(4'b0000, 8'd0, 1'b0, 1'b1);
    cyc(4'b1111, 8'd7, 1'b0, 1'b1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_ptr  = 0;
    m_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s1[i] = 0;
      s2[i] = 0;
    end
    rst  = 1'b1;
    req  = 4'b0000;
    step = 8'd0;
    hold = 1'b0;
    @(posedge clk);
    #1;

    // Reset state
    do_reset();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // Reset mid-op: grant b with step 3, reset the next cycle
    idle(1);
    cyc(4'b0010, 8'd3, 1'b0, 1'b0);
    cyc(4'b0000, 8'd0, 1'b0, 1'b1);
    idle(3);
    chk("midrst_b", 32'(b), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);

    // Single requester, 8 grants of step 1
    do_reset();
    for (int i = 0; i < 8; i++) cyc(4'b0001, 8'd1, 1'b0, 1'b0);
    idle(2);
    chk("single_a", 32'(a), 32'd8);
    chk("single_b", 32'(b), 32'd0);
    chk("single_d", 32'(d), 32'd0);

    // Fairness: all four requesting for 8 cycles
    do_reset();
    for (int i = 0; i < 8; i++) cyc(4'b1111, 8'd1, 1'b0, 1'b0);
    idle(2);
    chk("fair_a", 32'(a), 32'd2);
    chk("fair_b", 32'(b), 32'd2);
    chk("fair_c", 32'(c), 32'd2);
    chk("fair_d", 32'(d), 32'd2);

    // Forwarding: c granted three cycles in a row, step 2
    do_reset();
    for (int i = 0; i < 3; i++) cyc(4'b0100, 8'd2, 1'b0, 1'b0);
    idle(2);
    chk("fwd_c", 32'(c), 32'd6);

    // Hold: requests on b and d held off for 5 cycles, then released
    do_reset();
    for (int i = 0; i < 5; i++) cyc(4'b1010, 8'd1, 1'b1, 1'b0);
    cyc(4'b1010, 8'd1, 1'b0, 1'b0);
    cyc(4'b1000, 8'd1, 1'b0, 1'b0);
    idle(2);
    chk("hold_b", 32'(b), 32'd1);
    chk("hold_d", 32'(d), 32'd1);

    // Overflow on d
    do_reset();
    for (int i = 0; i < 254; i++) cyc(4'b1000, 8'd1, 1'b0, 1'b0);
    idle(2);
    chk("ovf_pre_d", 32'(d), 32'hFE);
    cyc(4'b1000, 8'd5, 1'b0, 1'b0);
    idle(2);
`ifdef CNT_BANK_ARB_SAT_EN
    chk("ovf_d", 32'(d), 32'hFF);
`else
    chk("ovf_d", 32'(d), 32'h03);
`endif

    // Random traffic with occasional hold and reset
    for (int i = 0; i < 600; i++) begin
      cyc(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
          1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 63) == 0));
    end
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
